alu_result_tx: RTL and testbench

Serial transmitter for the ALU result path: captures the ALU's `DATA_SIZE`-bit result on request and shifts it out on a single line as a UART-style frame: 1 start bit, `DATA_SIZE` data bits LSB first, 1 stop bit, no parity. It sits between the ALU output and the board's TX pin, so results leave the FPGA serially instead of on LEDs. Baud timing comes from an internal clock-divider counter; no external tick is required.

---
 rtl/alu_result_tx.sv | 150 +++++++++++++++
 tb/tb_alu_result_tx.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/alu_result_tx.sv
// alu_result_tx
//   UART-style serial transmitter for the ALU result path. On an accepted
//   request it captures the result and sends one frame:
//   start bit (0), DATA_SIZE data bits LSB first, stop bit (1), no parity.
//   Baud timing comes from an internal divide-by-CLKS_PER_BIT counter.
//
// Parameters
//   DATA_SIZE    : result width and data bits per frame
//   CLKS_PER_BIT : clock cycles per serial bit (>= 2)
//
// Ports
//   i_clk    : system clock, rising edge
//   i_reset  : synchronous active-high reset, highest priority
//   i_result : value to transmit, sampled only when a request is accepted
//   i_send   : level-sensitive request, acted on only while idle
//   o_tx     : registered serial line, idles high
//   o_busy   : high while a frame is in progress
//   o_done   : one-cycle pulse when a stop bit completes
module alu_result_tx #(
  parameter int unsigned DATA_SIZE    = 8,
  parameter int unsigned CLKS_PER_BIT = 10417
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic [DATA_SIZE-1:0] i_result,
  input  logic                 i_send,
  output logic                 o_tx,
  output logic                 o_busy,
  output logic                 o_done
);

  localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned BW = (DATA_SIZE > 1) ? $clog2(DATA_SIZE) : 1;
  localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_SIZE - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        baud_q, baud_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic [DATA_SIZE-1:0] shift_q, shift_d;
  logic                 tx_q, tx_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  logic                 baud_end;
  logic [DATA_SIZE-1:0] shift_next;

  assign baud_end   = (baud_q == BAUD_LAST);
  assign shift_next = shift_q >> 1;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // The line value for the next bit is registered on the same edge that
  // ends the current bit, so o_tx changes exactly on bit boundaries.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        tx_d   = 1'b1;
        busy_d = 1'b0;
        if (i_send) begin
          shift_d = i_result;
          baud_d  = '0;
          busy_d  = 1'b1;
          tx_d    = 1'b0;
          state_d = S_START;
        end
      end

      S_START: begin
        if (baud_end) begin
          baud_d  = '0;
          bit_d   = '0;
          tx_d    = shift_q[0];
          state_d = S_DATA;
        end else begin
          baud_d = baud_q + CW'(1);
        end
      end

      S_DATA: begin
        if (baud_end) begin
          baud_d = '0;
          if (bit_q == BIT_LAST) begin
            tx_d    = 1'b1;
            state_d = S_STOP;
          end else begin
            shift_d = shift_next;
            tx_d    = shift_next[0];
            bit_d   = bit_q + BW'(1);
          end
        end else begin
          baud_d = baud_q + CW'(1);
        end
      end

      S_STOP: begin
        if (baud_end) begin
          baud_d  = '0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          baud_d = baud_q + CW'(1);
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign o_tx   = tx_q;
  assign o_busy = busy_q;
  assign o_done = done_q;

endmodule

// File: tb/tb_alu_result_tx.sv
module tb_alu_result_tx;

  localparam int unsigned DS  = 8;
  localparam int unsigned CPB = 4;

  logic          clk;
  logic          rst;
  logic [DS-1:0] result;
  logic          send;
  logic          tx;
  logic          busy;
  logic          done;

  int checks = 0;
  int errors = 0;

  alu_result_tx #(
    .DATA_SIZE   (DS),
    .CLKS_PER_BIT(CPB)
  ) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .i_result(result),
    .i_send  (send),
    .o_tx    (tx),
    .o_busy  (busy),
    .o_done  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Frame bit i is the i-th bit on the line: [0]=start, [8:1]=data LSB first, [9]=stop.
  typedef struct {
    logic [7:0] data;
    logic [9:0] frame;
    int         disturb;  // cycle within the frame to inject FF + send pulse, -1 = none
  } vec_t;

  vec_t vecs[4];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Issues a one-cycle request and checks the whole frame cycle by cycle.
  task automatic run_frame(input logic [7:0] d, input logic [9:0] exp, input int disturb);
    int dcnt;
    chk("pre_busy", {31'd0, busy}, 32'd0);
    result = d;
    send   = 1'b1;
    tick();
    send   = 1'b0;
    dcnt   = 0;
    for (int c = 0; c < 40; c++) begin
      chk("frame_tx", {31'd0, tx}, {31'd0, exp[c / 4]});
      chk("frame_busy", {31'd0, busy}, 32'd1);
      if (done) dcnt++;
      if (c == disturb) begin
        result = 8'hFF;
        send   = 1'b1;
      end
      if (c == disturb + 1) send = 1'b0;
      tick();
    end
    chk("done_early", dcnt, 0);
    chk("end_done", {31'd0, done}, 32'd1);
    chk("end_busy", {31'd0, busy}, 32'd0);
    chk("end_tx", {31'd0, tx}, 32'd1);
    tick();
    chk("done_pulse_width", {31'd0, done}, 32'd0);
    chk("idle_tx", {31'd0, tx}, 32'd1);
  endtask

  initial begin
    logic       hist[90];
    int         done_at[$];
    int         run;
    vecs[0] = '{data: 8'hA5, frame: 10'b1101001010, disturb: -1};
    vecs[1] = '{data: 8'h3C, frame: 10'b1001111000, disturb: 13};
    vecs[2] = '{data: 8'h01, frame: 10'b1000000010, disturb: -1};
    vecs[3] = '{data: 8'h80, frame: 10'b1100000000, disturb: 30};

    // Reset held two cycles with a pending request.
    rst    = 1'b1;
    send   = 1'b1;
    result = 8'hA5;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("rst_tx", {31'd0, tx}, 32'd1);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);
    end
    send = 1'b0;
    rst  = 1'b0;
    tick();
    chk("post_rst_busy", {31'd0, busy}, 32'd0);
    chk("post_rst_tx", {31'd0, tx}, 32'd1);

    for (int v = 0; v < 4; v++) begin
      run_frame(vecs[v].data, vecs[v].frame, vecs[v].disturb);
      tick();
    end

    // Back-to-back frames with i_send held high.
    result = 8'h00;
    send   = 1'b1;
    tick();  // cycle 0 = first acceptance
    result = 8'hFF;
    for (int c = 0; c < 90; c++) begin
      hist[c] = tx;
      if (done) done_at.push_back(c);
      if (c == 50) send = 1'b0;
      tick();
    end
    for (int c = 0; c < 40; c++)
      chk("b2b_f1_tx", {31'd0, hist[c]}, (c < 36) ? 32'd0 : 32'd1);
    for (int c = 41; c < 81; c++)
      chk("b2b_f2_tx", {31'd0, hist[c]}, (c < 45) ? 32'd0 : 32'd1);
    run = 0;
    for (int c = 36; c < 41; c++) if (hist[c]) run++;
    chk("b2b_gap", run, 5);
    chk("b2b_gap_end", {31'd0, hist[41]}, 32'd0);
    chk("b2b_done_count", done_at.size(), 2);
    if (done_at.size() == 2) begin
      chk("b2b_done0", done_at[0], 40);
      chk("b2b_done_spacing", done_at[1] - done_at[0], 41);
    end

    // Reset during data bit 3 of 0x81.
    tick();
    result = 8'h81;
    send   = 1'b1;
    tick();
    send = 1'b0;
    for (int c = 0; c < 17; c++) tick();
    chk("mid_bit3_busy", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_tx", {31'd0, tx}, 32'd1);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    run = 0;
    for (int c = 0; c < 40; c++) begin
      if (done || busy || !tx) run++;
      tick();
    end
    chk("abort_quiet", run, 0);
    run_frame(8'h42, 10'b1010000100, -1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
